addsub_resp_checker: RTL and testbench

Hardware response checker for the 2-bit add/subtract unit. It samples the unit's stimulus (`m`, `a1:a0`, `b1:b0`) and response (`s2:s1`, `cout`) on each strobed cycle and compares the response against a built-in golden model. It also tracks coverage of all 32 input vectors, counts mismatches and captures the first failing vector. It is the response end of the add/sub stimulus interface: the stimulus generator drives the unit, and this block scores what comes back.

---
 rtl/addsub_pkg.sv | 31 +++
 rtl/addsub_model.sv | 15 +
 rtl/addsub_resp_checker.sv | 156 +++++++++++++++
 tb/tb_addsub_resp_checker.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and golden model for the 2-bit add/subtract unit checkers.
//   chk_state_t      : checker FSM states (idle, running, results held)
//   addsub_vec_t     : stimulus vector {m, a1, a0, b1, b0}
//   NUM_VECS         : number of distinct stimulus vectors
//   addsub_expected  : reference {cout, s2, s1} for a stimulus vector
package addsub_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } chk_state_t;

    typedef logic [4:0] addsub_vec_t;

    localparam int unsigned NUM_VECS = 32;

    // Subtract is A + ~B + 1 in 3 bits, so cout=1 signals "no borrow".
    function automatic logic [2:0] addsub_expected(addsub_vec_t vec);
        logic [2:0] op_a;
        logic [2:0] op_b;
        op_a = {1'b0, vec[3:2]};
        if (vec[4]) begin
            op_b = {1'b0, ~vec[1:0]} + 3'd1;
        end else begin
            op_b = {1'b0, vec[1:0]};
        end
        return op_a + op_b;
    endfunction

endpackage

// File: rtl/addsub_model.sv
// Combinational golden model of the 2-bit add/subtract unit.
//   vec_i : stimulus vector {m, a1, a0, b1, b0}
//   res_o : expected response {cout, s2, s1}
module addsub_model
    import addsub_pkg::*;
(
    input  addsub_vec_t vec_i,
    output logic [2:0]  res_o
);

    always_comb begin
        res_o = addsub_expected(vec_i);
    end

endmodule

// File: rtl/addsub_resp_checker.sv
// Response checker for the 2-bit add/subtract unit. Scores each valid sample
// against the golden model, tracks coverage of all 32 vectors, counts
// mismatches (saturating) and captures the first failing vector.
//   clk, rst_n          : clock, synchronous active-low reset
//   start, valid        : run start pulse, sample strobe
//   m, a1..a0, b1..b0   : sampled stimulus
//   s2..s1, cout        : sampled response
//   busy, done, pass    : run status
//   fail_cnt, cov_cnt   : mismatch count, distinct vectors seen
//   first_fail_*        : first mismatching vector / response and its valid flag
module addsub_resp_checker
    import addsub_pkg::*;
#(
    parameter int unsigned FAIL_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  valid,
    input  logic                  m,
    input  logic                  a0,
    input  logic                  a1,
    input  logic                  b0,
    input  logic                  b1,
    input  logic                  s1,
    input  logic                  s2,
    input  logic                  cout,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [FAIL_CNT_W-1:0] fail_cnt,
    output logic [5:0]            cov_cnt,
    output logic [4:0]            first_fail_vec,
    output logic [2:0]            first_fail_got,
    output logic                  first_fail_vld
);

    localparam logic [FAIL_CNT_W-1:0] FailMax = '1;

    chk_state_t            state_q, state_d;
    logic [NUM_VECS-1:0]   cov_map_q, cov_map_d;
    logic [5:0]            cov_cnt_q, cov_cnt_d;
    logic [FAIL_CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [4:0]            ff_vec_q, ff_vec_d;
    logic [2:0]            ff_got_q, ff_got_d;
    logic                  ff_vld_q, ff_vld_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;

    addsub_vec_t vec;
    logic [2:0]  resp;
    logic [2:0]  exp_resp;
    logic        mismatch;
    logic        new_vec;

    assign vec  = {m, a1, a0, b1, b0};
    assign resp = {cout, s2, s1};

    addsub_model u_model (
        .vec_i (vec),
        .res_o (exp_resp)
    );

    always_comb begin
        state_d    = state_q;
        cov_map_d  = cov_map_q;
        cov_cnt_d  = cov_cnt_q;
        fail_cnt_d = fail_cnt_q;
        ff_vec_d   = ff_vec_q;
        ff_got_d   = ff_got_q;
        ff_vld_d   = ff_vld_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        mismatch   = (resp != exp_resp);
        new_vec    = ~cov_map_q[vec];

        unique case (state_q)
            StIdle, StDone: begin
                // A valid on the start cycle is deliberately not scored.
                if (start) begin
                    state_d    = StRun;
                    cov_map_d  = '0;
                    cov_cnt_d  = '0;
                    fail_cnt_d = '0;
                    ff_vec_d   = '0;
                    ff_got_d   = '0;
                    ff_vld_d   = 1'b0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                end
            end
            StRun: begin
                if (valid) begin
                    if (mismatch && (fail_cnt_q != FailMax)) begin
                        fail_cnt_d = fail_cnt_q + 1'b1;
                    end
                    if (mismatch && !ff_vld_q) begin
                        ff_vec_d = vec;
                        ff_got_d = resp;
                        ff_vld_d = 1'b1;
                    end
                    cov_map_d[vec] = 1'b1;
                    cov_cnt_d      = cov_cnt_q + {5'd0, new_vec};
                    if (cov_cnt_d == 6'(NUM_VECS)) begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (fail_cnt_d == '0);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cov_map_q  <= '0;
            cov_cnt_q  <= '0;
            fail_cnt_q <= '0;
            ff_vec_q   <= '0;
            ff_got_q   <= '0;
            ff_vld_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cov_map_q  <= cov_map_d;
            cov_cnt_q  <= cov_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            ff_vec_q   <= ff_vec_d;
            ff_got_q   <= ff_got_d;
            ff_vld_q   <= ff_vld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_cnt       = fail_cnt_q;
    assign cov_cnt        = cov_cnt_q;
    assign first_fail_vec = ff_vec_q;
    assign first_fail_got = ff_got_q;
    assign first_fail_vld = ff_vld_q;

endmodule

// File: tb/tb_addsub_resp_checker.sv
module tb_addsub_resp_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, valid, m, a0, a1, b0, b1, s1, s2, cout;

    logic       busy, done, pass, first_fail_vld;
    logic [7:0] fail_cnt;
    logic [5:0] cov_cnt;
    logic [4:0] first_fail_vec;
    logic [2:0] first_fail_got;

    logic       d2_busy, d2_done, d2_pass, d2_ff_vld;
    logic [1:0] d2_fail_cnt;
    logic [5:0] d2_cov_cnt;
    logic [4:0] d2_ff_vec;
    logic [2:0] d2_ff_got;

    addsub_resp_checker #(.FAIL_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .valid(valid), .m(m),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .s1(s1), .s2(s2), .cout(cout),
        .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
        .cov_cnt(cov_cnt), .first_fail_vec(first_fail_vec),
        .first_fail_got(first_fail_got), .first_fail_vld(first_fail_vld)
    );

    // Narrow counter instance sees identical stimulus; used for saturation.
    addsub_resp_checker #(.FAIL_CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .valid(valid), .m(m),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .s1(s1), .s2(s2), .cout(cout),
        .busy(d2_busy), .done(d2_done), .pass(d2_pass), .fail_cnt(d2_fail_cnt),
        .cov_cnt(d2_cov_cnt), .first_fail_vec(d2_ff_vec),
        .first_fail_got(d2_ff_got), .first_fail_vld(d2_ff_vld)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    bit         md_run, md_done, md_ffv;
    bit         md_seen[32];
    int         md_cov, md_fail;
    logic [4:0] md_ffvec;
    logic [2:0] md_ffgot;

    // A+B, or A-B offset by 4 so bit 2 reads as "no borrow".
    function automatic logic [2:0] ref_exp(logic [4:0] v);
        int a, b, r;
        a = int'(v[3:2]);
        b = int'(v[1:0]);
        r = v[4] ? (a + 4 - b) : (a + b);
        return 3'(r);
    endfunction

    function automatic int sat(int v, int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic check(string name, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        md_cov = 0; md_fail = 0; md_ffv = 0; md_ffvec = '0; md_ffgot = '0;
        for (int i = 0; i < 32; i++) md_seen[i] = 0;
    endtask

    task automatic model_update();
        logic [4:0] v;
        logic [2:0] r;
        v = {m, a1, a0, b1, b0};
        r = {cout, s2, s1};
        if (!rst_n) begin
            md_run = 0; md_done = 0; model_clear();
        end else if (!md_run) begin
            if (start) begin
                md_run = 1; md_done = 0; model_clear();
            end
        end else if (valid) begin
            if (r != ref_exp(v)) begin
                md_fail++;
                if (!md_ffv) begin
                    md_ffv = 1; md_ffvec = v; md_ffgot = r;
                end
            end
            if (!md_seen[v]) begin
                md_seen[v] = 1;
                md_cov++;
            end
            if (md_cov == 32) begin
                md_run = 0; md_done = 1;
            end
        end
    endtask

    task automatic check_all();
        check("busy", int'(busy), int'(md_run));
        check("done", int'(done), int'(md_done));
        check("pass", int'(pass), int'(md_done && md_fail == 0));
        check("fail_cnt", int'(fail_cnt), sat(md_fail, 255));
        check("cov_cnt", int'(cov_cnt), md_cov);
        check("ff_vld", int'(first_fail_vld), int'(md_ffv));
        check("ff_vec", int'(first_fail_vec), int'(md_ffvec));
        check("ff_got", int'(first_fail_got), int'(md_ffgot));
        check("sat_fail_cnt", int'(d2_fail_cnt), sat(md_fail, 3));
        check("sat_pass", int'(d2_pass), int'(md_done && md_fail == 0));
    endtask

    // Apply one cycle of stimulus, then update model and compare after the edge.
    task automatic drive(logic st, logic vl, logic [4:0] v, logic [2:0] r);
        start = st;
        valid = vl;
        {m, a1, a0, b1, b0} = v;
        {cout, s2, s1} = r;
        @(posedge clk);
        #1;
        model_update();
        check_all();
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 5'd0, 3'd0);
    endtask

    typedef struct {
        logic [4:0] vec;
        logic [2:0] got;
        int         exp_fail;
        int         exp_cov;
        logic       exp_vld;
        logic [4:0] exp_ffvec;
    } rec_t;

    rec_t tbl[6];

    initial begin
        logic [4:0] v;
        logic [2:0] bad;
        int         budget;

        tbl[0] = '{5'b11001, 3'b000, 1, 1, 1'b1, 5'b11001};
        tbl[1] = '{5'b00000, 3'b111, 2, 2, 1'b1, 5'b11001};
        tbl[2] = '{5'b11001, 3'b101, 2, 2, 1'b1, 5'b11001};
        tbl[3] = '{5'b01101, 3'b100, 2, 3, 1'b1, 5'b11001};
        tbl[4] = '{5'b10110, 3'b011, 2, 4, 1'b1, 5'b11001};
        tbl[5] = '{5'b10110, 3'b111, 3, 4, 1'b1, 5'b11001};

        md_run = 0; md_done = 0; model_clear();
        rst_n = 1'b0;
        start = 1'b0; valid = 1'b0;
        {m, a1, a0, b1, b0} = '0;
        {cout, s2, s1} = '0;

        // Reset state.
        idle_cycle();
        idle_cycle();
        check("reset_busy", int'(busy), 0);
        check("reset_cov", int'(cov_cnt), 0);
        rst_n = 1'b1;

        // Valid in IDLE is ignored.
        drive(1'b0, 1'b1, 5'd3, 3'd7);
        check("idle_valid_cov", int'(cov_cnt), 0);

        // Clean sweep: done exactly one cycle after the 32nd sample.
        drive(1'b1, 1'b0, 5'd0, 3'd0);
        check("start_busy", int'(busy), 1);
        for (int i = 0; i < 32; i++) begin
            v = 5'(i);
            drive(1'b0, 1'b1, v, ref_exp(v));
            if (i == 30) check("sweep_not_done", int'(done), 0);
        end
        check("sweep_done", int'(done), 1);
        check("sweep_pass", int'(pass), 1);
        check("sweep_cov", int'(cov_cnt), 32);

        // Sweep with a single wrong response on m=1, A=1, B=2.
        drive(1'b1, 1'b0, 5'd0, 3'd0);
        for (int i = 0; i < 32; i++) begin
            v = 5'(i);
            drive(1'b0, 1'b1, v, (v == 5'b10110) ? 3'b111 : ref_exp(v));
        end
        check("err_fail_cnt", int'(fail_cnt), 1);
        check("err_ff_vec", int'(first_fail_vec), 5'b10110);
        check("err_ff_got", int'(first_fail_got), 3'b111);
        check("err_pass", int'(pass), 0);

        // Repeated vector adds no coverage; done only after the last new one.
        drive(1'b1, 1'b0, 5'd0, 3'd0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 5'b01101, 3'b100);
        check("rep_cov", int'(cov_cnt), 1);
        for (int i = 0; i < 32; i++) begin
            if (i != 13) begin
                v = 5'(i);
                if (i == 31) check("rep_not_done", int'(done), 0);
                drive(1'b0, 1'b1, v, ref_exp(v));
            end
        end
        check("rep_done", int'(done), 1);
        check("rep_fail", int'(fail_cnt), 0);

        // Table: first-fail retention and counting within one run.
        drive(1'b1, 1'b0, 5'd0, 3'd0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, tbl[i].vec, tbl[i].got);
            check("tbl_fail", int'(fail_cnt), tbl[i].exp_fail);
            check("tbl_cov", int'(cov_cnt), tbl[i].exp_cov);
            check("tbl_vld", int'(first_fail_vld), int'(tbl[i].exp_vld));
            check("tbl_ffvec", int'(first_fail_vec), int'(tbl[i].exp_ffvec));
        end

        // Start during RUN is ignored; a valid alongside it is still scored.
        drive(1'b1, 1'b1, 5'd1, ref_exp(5'd1));
        check("run_start_fail", int'(fail_cnt), 3);
        check("run_start_cov", int'(cov_cnt), 5);

        // Saturation of the narrow counter.
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 5'd0, 3'b001);
        check("sat_narrow", int'(d2_fail_cnt), 3);
        check("sat_wide", int'(fail_cnt), 9);

        // Reset mid-run after 10 samples.
        rst_n = 1'b0;
        idle_cycle();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 5'd0, 3'd0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 5'(i), 3'b110);
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 5'd20, 3'b000);
        check("rst_busy", int'(busy), 0);
        check("rst_fail", int'(fail_cnt), 0);
        check("rst_cov", int'(cov_cnt), 0);
        check("rst_vld", int'(first_fail_vld), 0);
        rst_n = 1'b1;

        // Start and valid together in IDLE: sample not scored.
        drive(1'b1, 1'b1, 5'd5, 3'b111);
        check("sv_cov", int'(cov_cnt), 0);
        check("sv_fail", int'(fail_cnt), 0);
        check("sv_busy", int'(busy), 1);

        // Randomized runs checked against the model.
        for (int run = 0; run < 4; run++) begin
            if (run > 0) drive(1'b1, 1'b0, 5'd0, 3'd0);
            budget = 3000;
            while (!md_done && budget > 0) begin
                v = 5'($urandom_range(0, 31));
                bad = 3'($urandom_range(1, 7));
                drive($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, v,
                      ($urandom_range(0, 15) == 0) ? (ref_exp(v) ^ bad) : ref_exp(v));
                budget--;
            end
            check("rand_completed", int'(md_done), 1);
        end

        // Start from DONE starts a fresh run.
        drive(1'b1, 1'b0, 5'd0, 3'd0);
        check("restart_done", int'(done), 0);
        check("restart_cov", int'(cov_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
